// File: rtl/fpu_result_capture.sv
// fpu_result_capture: captures FPU result words and status flags into a
// DEPTH-entry FIFO under a run/halt control FSM.
// Optional statistics counters are enabled by defining FPU_CAPTURE_STATS_EN.
module fpu_result_capture #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 16
) (
    input  logic                     clock_100Khz,
    input  logic                     reset,
    input  logic                     res_valid,
    input  logic [31:0]              res_data,
    input  logic [3:0]               res_status,
    input  logic                     start,
    input  logic                     stop,
    input  logic                     clear,
    input  logic                     rd_en,
    output logic [35:0]              rd_data,
    output logic                     rd_valid,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     dropped,
    output logic [1:0]               state,
    output logic [CNT_W-1:0]         cnt_ovf,
    output logic [CNT_W-1:0]         cnt_unf,
    output logic [CNT_W-1:0]         cnt_inx
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_HALT = 2'b10
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [35:0]     r_mem [DEPTH];
    logic [AW-1:0]   r_wptr;
    logic [AW-1:0]   r_rptr;
    logic [LW-1:0]   r_level;
    logic            r_dropped;
    logic [35:0]     r_rd_data;
    logic            r_rd_valid;

    logic            w_empty;
    logic            w_full;
    logic            w_run;
    logic            w_pop;
    logic            w_push;
    logic            w_drop;

    // A pop frees a slot in the same cycle, so a full FIFO can still accept
    // a push when it is also being read. Clear discards both.
    assign w_empty = (r_level == '0);
    assign w_full  = (r_level == LW'(DEPTH));
    assign w_run   = (r_state == S_RUN);
    assign w_pop   = rd_en & ~w_empty & ~clear;
    assign w_push  = w_run & res_valid & ~clear & (~w_full | w_pop);
    assign w_drop  = w_run & res_valid & ~clear & w_full & ~w_pop;

    // Control state register
    always_ff @(posedge clock_100Khz or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next state: stop has priority, then clear, then drop
    always_comb begin
        w_state_nxt = r_state;
        if (r_state != S_IDLE && stop) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (start) w_state_nxt = S_RUN;
                S_RUN:   if (!clear && w_drop) w_state_nxt = S_HALT;
                S_HALT:  if (clear) w_state_nxt = S_RUN;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // Storage array; contents are don't-care until written
    always_ff @(posedge clock_100Khz) begin
        if (w_push) r_mem[r_wptr] <= {res_status, res_data};
    end

    // Pointers, occupancy and sticky drop flag
    always_ff @(posedge clock_100Khz or posedge reset) begin
        if (reset) begin
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_level   <= '0;
            r_dropped <= 1'b0;
        end else if (clear) begin
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_level   <= '0;
            r_dropped <= 1'b0;
        end else begin
            if (w_push) r_wptr <= r_wptr + AW'(1);
            if (w_pop)  r_rptr <= r_rptr + AW'(1);
            r_level <= r_level + LW'(w_push) - LW'(w_pop);
            if (w_drop) r_dropped <= 1'b1;
        end
    end

    // Registered read port; rd_data holds its last value between pops
    always_ff @(posedge clock_100Khz or posedge reset) begin
        if (reset) begin
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= w_pop;
            if (w_pop) r_rd_data <= r_mem[r_rptr];
        end
    end

`ifdef FPU_CAPTURE_STATS_EN
    logic [CNT_W-1:0] r_cnt_ovf;
    logic [CNT_W-1:0] r_cnt_unf;
    logic [CNT_W-1:0] r_cnt_inx;

    // Saturating status counters, advanced only on accepted pushes
    always_ff @(posedge clock_100Khz or posedge reset) begin
        if (reset || clear) begin
            r_cnt_ovf <= '0;
            r_cnt_unf <= '0;
            r_cnt_inx <= '0;
        end else if (w_push) begin
            if (res_status[1] && r_cnt_ovf != '1) r_cnt_ovf <= r_cnt_ovf + CNT_W'(1);
            if (res_status[2] && r_cnt_unf != '1) r_cnt_unf <= r_cnt_unf + CNT_W'(1);
            if (res_status[3] && r_cnt_inx != '1) r_cnt_inx <= r_cnt_inx + CNT_W'(1);
        end
    end

    assign cnt_ovf = r_cnt_ovf;
    assign cnt_unf = r_cnt_unf;
    assign cnt_inx = r_cnt_inx;
`else
    assign cnt_ovf = '0;
    assign cnt_unf = '0;
    assign cnt_inx = '0;
`endif

    assign rd_data  = r_rd_data;
    assign rd_valid = r_rd_valid;
    assign empty    = w_empty;
    assign full     = w_full;
    assign level    = r_level;
    assign dropped  = r_dropped;
    assign state    = r_state;

endmodule

// File: tb/tb_fpu_result_capture.sv
// Randomized + directed bench for fpu_result_capture with a queue-based
// reference model and a scoreboard monitor on the read port.
module tb_fpu_result_capture;

    localparam int DEPTH = 8;
    localparam int CNT_W = 16;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic                     clk = 1'b0;
    logic                     reset;
    logic                     res_valid;
    logic [31:0]              res_data;
    logic [3:0]               res_status;
    logic                     start, stop, clear, rd_en;
    logic [35:0]              rd_data;
    logic                     rd_valid, empty, full, dropped;
    logic [$clog2(DEPTH):0]   level;
    logic [1:0]               state;
    logic [CNT_W-1:0]         cnt_ovf, cnt_unf, cnt_inx;

    fpu_result_capture #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clock_100Khz(clk), .reset(reset), .res_valid(res_valid),
        .res_data(res_data), .res_status(res_status), .start(start),
        .stop(stop), .clear(clear), .rd_en(rd_en), .rd_data(rd_data),
        .rd_valid(rd_valid), .empty(empty), .full(full), .level(level),
        .dropped(dropped), .state(state), .cnt_ovf(cnt_ovf),
        .cnt_unf(cnt_unf), .cnt_inx(cnt_inx)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: plain queue plus a few scalars
    logic [35:0] mfifo[$];
    logic [35:0] sb[$];
    int          mst   = 0;   // 0 idle, 1 run, 2 halt
    bit          mdrop = 0;
    int          mo = 0, mu = 0, mi = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Advance model by one clock using the inputs currently driven
    task automatic model_step();
        bit pop, push, drp;
        pop  = rd_en && mfifo.size() > 0 && !clear;
        push = mst == 1 && res_valid && !clear && (mfifo.size() < DEPTH || pop);
        drp  = mst == 1 && res_valid && !clear && mfifo.size() == DEPTH && !pop;
        if (clear) begin
            mfifo.delete();
            mdrop = 0; mo = 0; mu = 0; mi = 0;
        end else begin
            if (pop)  sb.push_back(mfifo.pop_front());
            if (push) begin
                mfifo.push_back({res_status, res_data});
`ifdef FPU_CAPTURE_STATS_EN
                if (res_status[1] && mo < CMAX) mo++;
                if (res_status[2] && mu < CMAX) mu++;
                if (res_status[3] && mi < CMAX) mi++;
`endif
            end
            if (drp) mdrop = 1;
        end
        if (mst != 0 && stop) mst = 0;
        else if (mst == 0 && start) mst = 1;
        else if (mst == 1 && !clear && drp) mst = 2;
        else if (mst == 2 && clear) mst = 1;
    endtask

    task automatic check_outs();
        chk("level",   level,   mfifo.size());
        chk("empty",   empty,   mfifo.size() == 0);
        chk("full",    full,    mfifo.size() == DEPTH);
        chk("dropped", dropped, mdrop);
        chk("state",   state,   mst);
        chk("cnt_ovf", cnt_ovf, mo);
        chk("cnt_unf", cnt_unf, mu);
        chk("cnt_inx", cnt_inx, mi);
    endtask

    // One cycle: drive at negedge, model, check at the next negedge
    task automatic cyc(input bit rv, input logic [31:0] d, input logic [3:0] s,
                       input bit rd, input bit st, input bit sp, input bit cl);
        res_valid = rv; res_data = d; res_status = s;
        rd_en = rd; start = st; stop = sp; clear = cl;
        model_step();
        @(negedge clk);
        check_outs();
    endtask

    // Scoreboard monitor: every rd_valid pulse must match the oldest expected pop
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rd_valid) begin
                if (sb.size() == 0) chk("rd_valid_spurious", 1, 0);
                else                chk("rd_data", rd_data, sb.pop_front());
            end
        end
    end

    initial begin
        reset = 1'b1; res_valid = 0; res_data = 0; res_status = 0;
        rd_en = 0; start = 0; stop = 0; clear = 0;
        #3;
        chk("rst_rd_data", rd_data, 0);
        chk("rst_rd_valid", rd_valid, 0);
        check_outs();
        @(negedge clk);
        reset = 1'b0;

        // Basic push then read: 3.75 exact
        cyc(0, 0, 0, 0, 1, 0, 0);
        cyc(1, 32'h40700000, 4'h1, 0, 0, 0, 0);
        chk("first_level", level, 1);
        cyc(0, 0, 0, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);

        // Overflow: 9 pushes drop and halt, 10th ignored
        for (int i = 0; i < 10; i++) cyc(1, $urandom, 4'h1, 0, 0, 0, 0);
        chk("ovf_level", level, DEPTH);
        chk("ovf_state", state, 2);
        cyc(0, 0, 0, 0, 0, 0, 1);       // clear in HALT returns to RUN

        // Full FIFO with simultaneous push/pop across pointer wrap
        for (int i = 0; i < DEPTH; i++) cyc(1, $urandom, 4'($urandom_range(0, 15)), 0, 0, 0, 0);
        for (int i = 0; i < 12; i++)    cyc(1, $urandom, 4'($urandom_range(0, 15)), 1, 0, 0, 0);
        chk("wrap_level", level, DEPTH);
        for (int i = 0; i < DEPTH + 1; i++) cyc(0, 0, 0, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 1);

        // Statistics
        for (int i = 0; i < 3; i++) cyc(1, $urandom, 4'b0010, 0, 0, 0, 0);
        cyc(1, $urandom, 4'b1000, 0, 0, 0, 0);
`ifdef FPU_CAPTURE_STATS_EN
        chk("stat_ovf3", cnt_ovf, 3);
        chk("stat_inx1", cnt_inx, 1);
`endif
        cyc(0, 0, 0, 0, 0, 0, 1);
        chk("clr_empty", empty, 1);

        // Read while empty, then stop and push in IDLE
        cyc(0, 0, 0, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 1, 0);
        cyc(1, $urandom, 4'h8, 0, 0, 0, 0);
        chk("idle_level", level, 0);

        // Reset with 5 entries and a read in flight
        cyc(0, 0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 5; i++) cyc(1, $urandom, 4'($urandom_range(0, 15)), 0, 0, 0, 0);
        res_valid = 0; rd_en = 1;
        model_step();
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("amid_rd_valid", rd_valid, 0);
        chk("amid_rd_data", rd_data, 0);
        mfifo.delete(); mst = 0; mdrop = 0; mo = 0; mu = 0; mi = 0;
        check_outs();
        rd_en = 0;
        @(negedge clk);
        reset = 1'b0;

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++)
            cyc($urandom_range(0, 1), $urandom, 4'($urandom_range(0, 15)),
                $urandom_range(0, 9) < 4, $urandom_range(0, 9) == 0,
                $urandom_range(0, 49) == 0, $urandom_range(0, 79) == 0);

        // Drain and confirm every expected pop was seen
        for (int i = 0; i < DEPTH + 2; i++) cyc(0, 0, 0, 1, 0, 0, 0);
        @(negedge clk);
        chk("sb_drained", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
